// File: rtl/seg7_capture_if.sv
// Seven-segment capture bus: segment lines in, recovered nibble out.
// Ports: Qa..Qg, ready (to capture); A..D, valid, err, overrun (from capture).
interface seg7_capture_if;
    logic Qa;
    logic Qb;
    logic Qc;
    logic Qd;
    logic Qe;
    logic Qf;
    logic Qg;
    logic ready;
    logic A;
    logic B;
    logic C;
    logic D;
    logic valid;
    logic err;
    logic overrun;

    modport slave (
        input  Qa, Qb, Qc, Qd, Qe, Qf, Qg, ready,
        output A, B, C, D, valid, err, overrun
    );

    modport master (
        output Qa, Qb, Qc, Qd, Qe, Qf, Qg, ready,
        input  A, B, C, D, valid, err, overrun
    );
endinterface

// File: rtl/seg7_capture.sv
// Recovers the hex nibble from sampled seven-segment lines, debounced,
// emitting each new stable digit once on a valid/ready output register.
// Ports: clk, rst (async, active-high), bus (seg7_capture_if.slave).
// Optional: SEG7_CAPTURE_ALT_GLYPH_EN accepts S=07 as 7 and S=67 as 9.
module seg7_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    seg7_capture_if.slave   bus
);
    typedef enum logic [1:0] {SETTLE, ACCEPT, HOLD} state_t;

    localparam logic [3:0] CNT_MAX  = 4'(STABLE_CYCLES);
    localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

    // Returns {illegal, code}; illegal patterns report code 0.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F:   decode = {1'b0, 4'h0};
            7'h06:   decode = {1'b0, 4'h1};
            7'h5B:   decode = {1'b0, 4'h2};
            7'h4F:   decode = {1'b0, 4'h3};
            7'h66:   decode = {1'b0, 4'h4};
            7'h6D:   decode = {1'b0, 4'h5};
            7'h7D:   decode = {1'b0, 4'h6};
            7'h27:   decode = {1'b0, 4'h7};
            7'h7F:   decode = {1'b0, 4'h8};
            7'h6F:   decode = {1'b0, 4'h9};
            7'h77:   decode = {1'b0, 4'hA};
            7'h7C:   decode = {1'b0, 4'hB};
            7'h39:   decode = {1'b0, 4'hC};
            7'h5E:   decode = {1'b0, 4'hD};
            7'h79:   decode = {1'b0, 4'hE};
            7'h71:   decode = {1'b0, 4'hF};
`ifdef SEG7_CAPTURE_ALT_GLYPH_EN
            7'h07:   decode = {1'b0, 4'h7};
            7'h67:   decode = {1'b0, 4'h9};
`endif
            default: decode = {1'b1, 4'h0};
        endcase
    endfunction

    logic [6:0] seg_in;
    logic [6:0] s1_q, s1_d;
    logic [6:0] s2_q, s2_d;
    logic [3:0] cnt_q, cnt_d;
    state_t     state_q, state_d;
    logic [6:0] last_q, last_d;
    logic [3:0] word_q, word_d;
    logic       err_q, err_d;
    logic       valid_q, valid_d;
    logic       ovr_q, ovr_d;
    logic       chg;
    logic       emit;
    logic [4:0] dec;

    assign seg_in = {bus.Qg, bus.Qf, bus.Qe, bus.Qd, bus.Qc, bus.Qb, bus.Qa};

    always_comb begin
        s1_d    = seg_in;
        s2_d    = s1_q;
        // s2 is about to take a new value at the coming edge.
        chg     = (s1_q != s2_q);
        cnt_d   = cnt_q;
        state_d = state_q;
        last_d  = last_q;
        emit    = 1'b0;
        dec     = decode(s2_q);
        word_d  = word_q;
        err_d   = err_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (chg) begin
            cnt_d = 4'd0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 4'd1;
        end

        case (state_q)
            SETTLE: begin
                if (!chg && cnt_q == CNT_LAST) begin
                    state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                // A change landing during ACCEPT must not be lost in HOLD.
                state_d = chg ? SETTLE : HOLD;
                if (s2_q == 7'h00) begin
                    last_d = 7'h00;
                end else if (s2_q != last_q) begin
                    last_d = s2_q;
                    emit   = 1'b1;
                end
            end
            HOLD: begin
                if (chg) begin
                    state_d = SETTLE;
                end
            end
            default: state_d = SETTLE;
        endcase

        if (emit) begin
            if (!valid_q || bus.ready) begin
                word_d  = dec[3:0];
                err_d   = dec[4];
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && bus.ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 7'h00;
            s2_q    <= 7'h00;
            cnt_q   <= 4'd0;
            state_q <= SETTLE;
            last_q  <= 7'h00;
            word_q  <= 4'h0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            last_q  <= last_d;
            word_q  <= word_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.A       = word_q[0];
    assign bus.B       = word_q[1];
    assign bus.C       = word_q[2];
    assign bus.D       = word_q[3];
    assign bus.err     = err_q;
    assign bus.valid   = valid_q;
    assign bus.overrun = ovr_q;
endmodule
